// File: rtl/axi_xbar_pkg.sv
// Shared types and helpers for the crossbar response return paths.
// Holds the BRESP encoding and the select-vector encoder used by every master port.
package axi_xbar_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  localparam int RECEIVER_NUM_DEF = 8;
  localparam int IDX_WIDTH        = $clog2(RECEIVER_NUM_DEF);

  // Widest select vector the encoder accepts; callers zero-extend narrower ones.
  localparam int SEL_MAX = 64;

  // Lowest set bit wins; an all-zero vector encodes to 0.
  function automatic int onehot_to_idx(input logic [SEL_MAX-1:0] onehot);
    int idx;
    idx = 0;
    for (int i = SEL_MAX - 1; i >= 0; i--) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/idx_fifo.sv
// In-order FIFO of slave indices; read data is the current head, available while non-empty.
// Pushes while full and pops while empty are ignored.
module idx_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/b_resp_return.sv
// Write-response return path for one master port: tracks AW destinations in order
// and forwards B only from the slave owed the oldest response, via a one-entry output register.
module b_resp_return
  import axi_xbar_pkg::*;
#(
  parameter int RECEIVER_NUM      = 8,
  parameter int ID_WIDTH          = 4,
  parameter int OUTSTANDING_DEPTH = 8
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETn,
  input  logic                                 aw_push,
  input  logic [RECEIVER_NUM-1:0]              aw_slave_sel,
  output logic                                 aw_stall,
  output logic [$clog2(OUTSTANDING_DEPTH):0]   outstanding,
  input  logic [RECEIVER_NUM-1:0]              slv_bvalid,
  input  logic [ID_WIDTH-1:0]                  slv_bid   [RECEIVER_NUM],
  input  logic [1:0]                           slv_bresp [RECEIVER_NUM],
  output logic [RECEIVER_NUM-1:0]              slv_bready,
  output logic                                 m_bvalid,
  output logic [ID_WIDTH-1:0]                  m_bid,
  output logic [1:0]                           m_bresp,
  input  logic                                 m_bready
);

  localparam int IDX_W = $clog2(RECEIVER_NUM);

  logic [SEL_MAX-1:0]  sel_wide;
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    head_idx;
  logic                fifo_push, fifo_full, fifo_empty;
  logic                head_ready, head_bvalid, b_pop;

  logic                m_bvalid_reg, m_bvalid_next;
  logic [ID_WIDTH-1:0] m_bid_reg, m_bid_next;
  resp_t               m_bresp_reg, m_bresp_next;

  always_comb begin
    sel_wide                   = '0;
    sel_wide[RECEIVER_NUM-1:0] = aw_slave_sel;
  end

  assign push_idx  = IDX_W'(onehot_to_idx(sel_wide));
  // A zero-hot select carries no destination, so it is not tracked.
  assign fifo_push = aw_push & (|aw_slave_sel) & ~fifo_full;

  idx_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (OUTSTANDING_DEPTH)
  ) u_idx_fifo (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .push    (fifo_push),
    .pop     (b_pop),
    .din     (push_idx),
    .dout    (head_idx),
    .count   (outstanding),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Stall comes from the registered count only; a pop in the same cycle does not free a slot early.
  assign aw_stall = fifo_full;

  // The output register can take a new beat when it is empty or draining this cycle.
  assign head_ready  = ~fifo_empty & (~m_bvalid_reg | m_bready);
  assign head_bvalid = slv_bvalid[head_idx];
  assign b_pop       = head_ready & head_bvalid;

  generate
    for (genvar gi = 0; gi < RECEIVER_NUM; gi++) begin : g_ready
      localparam logic [IDX_W-1:0] SLAVE_IDX = IDX_W'(gi);
      assign slv_bready[gi] = head_ready & (head_idx == SLAVE_IDX);
    end
  endgenerate

  always_comb begin
    m_bvalid_next = m_bvalid_reg;
    m_bid_next    = m_bid_reg;
    m_bresp_next  = m_bresp_reg;
    if (b_pop) begin
      m_bvalid_next = 1'b1;
      m_bid_next    = slv_bid[head_idx];
      m_bresp_next  = resp_t'(slv_bresp[head_idx]);
    end else if (m_bready) begin
      m_bvalid_next = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      m_bvalid_reg <= 1'b0;
      m_bid_reg    <= '0;
      m_bresp_reg  <= OKAY;
    end else begin
      m_bvalid_reg <= m_bvalid_next;
      m_bid_reg    <= m_bid_next;
      m_bresp_reg  <= m_bresp_next;
    end
  end

  assign m_bvalid = m_bvalid_reg;
  assign m_bid    = m_bid_reg;
  assign m_bresp  = m_bresp_reg;

endmodule

// File: tb/tb_b_resp_return.sv
// Bench for b_resp_return: directed scenarios plus random traffic, all checked every
// cycle against a queue-based model of the in-order response return path.
module tb_b_resp_return;

  localparam int RN    = 8;
  localparam int IW    = 4;
  localparam int DEPTH = 8;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          aw_push;
  logic [RN-1:0] aw_slave_sel;
  logic          aw_stall;
  logic [3:0]    outstanding;
  logic [RN-1:0] slv_bvalid;
  logic [IW-1:0] slv_bid   [RN];
  logic [1:0]    slv_bresp [RN];
  logic [RN-1:0] slv_bready;
  logic          m_bvalid;
  logic [IW-1:0] m_bid;
  logic [1:0]    m_bresp;
  logic          m_bready;

  always #5 ACLK = ~ACLK;

  b_resp_return #(
    .RECEIVER_NUM      (RN),
    .ID_WIDTH          (IW),
    .OUTSTANDING_DEPTH (DEPTH)
  ) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .aw_push      (aw_push),
    .aw_slave_sel (aw_slave_sel),
    .aw_stall     (aw_stall),
    .outstanding  (outstanding),
    .slv_bvalid   (slv_bvalid),
    .slv_bid      (slv_bid),
    .slv_bresp    (slv_bresp),
    .slv_bready   (slv_bready),
    .m_bvalid     (m_bvalid),
    .m_bid        (m_bid),
    .m_bresp      (m_bresp),
    .m_bready     (m_bready)
  );

  int compared         = 0;
  int mismatched       = 0;
  int stall_violations = 0;
  bit check_en         = 1'b0;

  // Model state: list of slaves owed a B (oldest first) and the master-side beat.
  int            q[$];
  bit            exp_mv;
  logic [IW-1:0] exp_bid;
  logic [1:0]    exp_bresp;
  logic [RN-1:0] exp_rdy;
  bit            mdl_pop;
  bit            mdl_full;
  int            mdl_head;
  int            mdl_low;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream must never push while stalled; every occurrence is recorded.
  always @(posedge ACLK) begin
    if (ARESETn && aw_push && aw_stall) stall_violations++;
  end

  always @(negedge ACLK) begin
    if (check_en) begin
      if (!ARESETn) begin
        q.delete();
        exp_mv    = 1'b0;
        exp_bid   = '0;
        exp_bresp = '0;
      end
      exp_rdy = '0;
      if (ARESETn && q.size() != 0 && (!exp_mv || m_bready)) exp_rdy[q[0]] = 1'b1;
      chk("slv_bready",  32'(slv_bready),  32'(exp_rdy));
      chk("outstanding", 32'(outstanding), 32'(q.size()));
      chk("aw_stall",    32'(aw_stall),    32'(q.size() == DEPTH));
      chk("m_bvalid",    32'(m_bvalid),    32'(exp_mv));
      chk("m_bid",       32'(m_bid),       32'(exp_bid));
      chk("m_bresp",     32'(m_bresp),     32'(exp_bresp));
      if (ARESETn) begin
        mdl_full = (q.size() == DEPTH);
        mdl_pop  = 1'b0;
        if (exp_rdy != '0) begin
          mdl_head = q[0];
          mdl_pop  = slv_bvalid[mdl_head];
        end
        if (mdl_pop) begin
          void'(q.pop_front());
          exp_mv    = 1'b1;
          exp_bid   = slv_bid[mdl_head];
          exp_bresp = slv_bresp[mdl_head];
        end else if (m_bready) begin
          exp_mv = 1'b0;
        end
        mdl_low = -1;
        for (int i = 0; i < RN; i++) begin
          if (aw_slave_sel[i] && mdl_low < 0) mdl_low = i;
        end
        if (aw_push && !mdl_full && mdl_low >= 0) q.push_back(mdl_low);
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic neg();
    @(negedge ACLK);
  endtask

  task automatic drain(input string name);
    slv_bvalid = '1;
    m_bready   = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (outstanding == 0) break;
    end
    chk(name, 32'(outstanding), 32'd0);
    slv_bvalid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn      = 1'b0;
    aw_push      = 1'b0;
    aw_slave_sel = '0;
    slv_bvalid   = '0;
    m_bready     = 1'b1;
    for (int i = 0; i < RN; i++) begin
      slv_bid[i]   = '0;
      slv_bresp[i] = '0;
    end
    exp_mv    = 1'b0;
    exp_bid   = '0;
    exp_bresp = '0;
    check_en  = 1'b1;

    repeat (2) neg();
    chk("rst_m_bvalid",    32'(m_bvalid),    32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_aw_stall",    32'(aw_stall),    32'd0);
    chk("rst_slv_bready",  32'(slv_bready),  32'd0);
    chk("rst_m_bresp",     32'(m_bresp),     32'd0);
    tick();
    ARESETn = 1'b1;

    // Single write to slave 2
    aw_push = 1'b1; aw_slave_sel = 8'h04;
    tick();
    aw_push = 1'b0; aw_slave_sel = '0;
    slv_bvalid = 8'h04; slv_bid[2] = 4'd3; slv_bresp[2] = 2'd0;
    neg();
    chk("t1_rdy",  32'(slv_bready),  32'h04);
    chk("t1_out1", 32'(outstanding), 32'd1);
    tick();
    slv_bvalid = '0;
    neg();
    chk("t1_mbv",   32'(m_bvalid),    32'd1);
    chk("t1_bid",   32'(m_bid),       32'd3);
    chk("t1_bresp", 32'(m_bresp),     32'd0);
    chk("t1_out0",  32'(outstanding), 32'd0);

    // Ordering: slave 5 then slave 1; slave 1 answers first but must wait
    tick();
    aw_push = 1'b1; aw_slave_sel = 8'h20;
    tick();
    aw_slave_sel = 8'h02; slv_bvalid = 8'h02; slv_bid[1] = 4'd7; slv_bresp[1] = 2'd1;
    neg();
    chk("t2_rdy_a", 32'(slv_bready), 32'h20);
    tick();
    aw_push = 1'b0; aw_slave_sel = '0;
    slv_bvalid = 8'h22; slv_bid[5] = 4'd2; slv_bresp[5] = 2'd0;
    neg();
    chk("t2_rdy_b", 32'(slv_bready), 32'h20);
    tick();
    slv_bvalid = 8'h02;
    neg();
    chk("t2_mbv_a", 32'(m_bvalid),   32'd1);
    chk("t2_bid_a", 32'(m_bid),      32'd2);
    chk("t2_rdy_c", 32'(slv_bready), 32'h02);
    tick();
    slv_bvalid = '0;
    neg();
    chk("t2_bid_b", 32'(m_bid),       32'd7);
    chk("t2_out0",  32'(outstanding), 32'd0);

    // Full: 8 pushes, a 9th is dropped, one pop clears the stall
    tick();
    for (int i = 0; i < 8; i++) begin
      aw_push = 1'b1; aw_slave_sel = 8'h01 << i;
      tick();
    end
    aw_push = 1'b0; aw_slave_sel = '0;
    neg();
    chk("t3_out8",  32'(outstanding), 32'd8);
    chk("t3_stall", 32'(aw_stall),    32'd1);
    tick();
    aw_push = 1'b1; aw_slave_sel = 8'h80;
    tick();
    aw_push = 1'b0; aw_slave_sel = '0;
    neg();
    chk("t3_out8_after_drop", 32'(outstanding), 32'd8);
    tick();
    slv_bvalid = 8'h01; slv_bid[0] = 4'hA;
    neg();
    chk("t3_rdy", 32'(slv_bready), 32'h01);
    tick();
    slv_bvalid = '0;
    neg();
    chk("t3_unstall", 32'(aw_stall),    32'd0);
    chk("t3_out7",    32'(outstanding), 32'd7);
    tick();
    drain("t3_drain");

    // Backpressure then back-to-back delivery
    tick();
    m_bready = 1'b0;
    aw_push = 1'b1; aw_slave_sel = 8'h08;
    tick();
    aw_slave_sel = 8'h40;
    tick();
    aw_slave_sel = 8'h08;
    tick();
    aw_push = 1'b0; aw_slave_sel = '0;
    slv_bvalid = 8'h08; slv_bid[3] = 4'd9; slv_bresp[3] = 2'd2;
    neg();
    chk("t4_rdy_a", 32'(slv_bready), 32'h08);
    tick();
    slv_bid[3] = 4'd1; slv_bresp[3] = 2'd1;
    slv_bvalid = 8'h48; slv_bid[6] = 4'd5; slv_bresp[6] = 2'd3;
    for (int k = 0; k < 5; k++) begin
      neg();
      chk("t4_hold_rdy",   32'(slv_bready), 32'h00);
      chk("t4_hold_mbv",   32'(m_bvalid),   32'd1);
      chk("t4_hold_bid",   32'(m_bid),      32'd9);
      chk("t4_hold_bresp", 32'(m_bresp),    32'd2);
      tick();
    end
    m_bready = 1'b1;
    neg();
    chk("t4_rdy_b", 32'(slv_bready), 32'h40);
    tick();
    neg();
    chk("t4_b2b_mbv",   32'(m_bvalid),   32'd1);
    chk("t4_b2b_bid",   32'(m_bid),      32'd5);
    chk("t4_b2b_bresp", 32'(m_bresp),    32'd3);
    chk("t4_rdy_c",     32'(slv_bready), 32'h08);
    tick();
    slv_bvalid = '0;
    neg();
    chk("t4_last_bid", 32'(m_bid),    32'd1);
    chk("t4_last_mbv", 32'(m_bvalid), 32'd1);
    tick();
    neg();
    chk("t4_idle_mbv", 32'(m_bvalid), 32'd0);

    // Edge selects, simultaneous push/pop with pointer wrap
    tick();
    aw_push = 1'b1; aw_slave_sel = '0;
    tick();
    aw_push = 1'b0;
    neg();
    chk("t5_zero_sel", 32'(outstanding), 32'd0);
    tick();
    aw_push = 1'b1; aw_slave_sel = 8'hA0;
    tick();
    aw_slave_sel = 8'h01;
    tick();
    aw_slave_sel = 8'h02;
    tick();
    aw_push = 1'b0; aw_slave_sel = '0;
    neg();
    chk("t5_multi_sel", 32'(slv_bready),  32'h20);
    chk("t5_out3",      32'(outstanding), 32'd3);
    tick();
    for (int i = 0; i < RN; i++) begin
      slv_bid[i] = 4'(i); slv_bresp[i] = 2'(i);
    end
    for (int k = 0; k < 6; k++) begin
      aw_push = 1'b1; aw_slave_sel = 8'h01 << ((k + 3) % 8);
      slv_bvalid = '1;
      tick();
    end
    aw_push = 1'b0; aw_slave_sel = '0; slv_bvalid = '0;
    neg();
    chk("t5_pushpop_out", 32'(outstanding), 32'd3);
    chk("t5_pushpop_bid", 32'(m_bid),       32'd5);
    tick();
    drain("t5_drain");

    // Asynchronous reset with work in flight
    tick();
    m_bready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      aw_push = 1'b1; aw_slave_sel = 8'h01 << k;
      tick();
    end
    aw_push = 1'b0; aw_slave_sel = '0;
    slv_bvalid = 8'h01; slv_bid[0] = 4'hC;
    tick();
    slv_bvalid = '0;
    neg();
    chk("t6_pre_mbv", 32'(m_bvalid),    32'd1);
    chk("t6_pre_out", 32'(outstanding), 32'd4);
    tick();
    ARESETn = 1'b0;
    #1;
    chk("t6_rst_mbv",   32'(m_bvalid),    32'd0);
    chk("t6_rst_out",   32'(outstanding), 32'd0);
    chk("t6_rst_stall", 32'(aw_stall),    32'd0);
    chk("t6_rst_rdy",   32'(slv_bready),  32'd0);
    tick();
    ARESETn  = 1'b1;
    m_bready = 1'b1;
    neg();
    chk("t6_post_out", 32'(outstanding), 32'd0);

    // Random traffic against the model
    tick();
    for (int c = 0; c < 3000; c++) begin
      int r;
      aw_push = (($urandom % 3) != 0) && !aw_stall;
      r = int'($urandom % 8);
      if (r == 0)      aw_slave_sel = '0;
      else if (r < 3)  aw_slave_sel = 8'($urandom);
      else             aw_slave_sel = 8'h01 << ($urandom % 8);
      slv_bvalid = 8'($urandom);
      for (int i = 0; i < RN; i++) begin
        slv_bid[i]   = 4'($urandom);
        slv_bresp[i] = 2'($urandom);
      end
      m_bready = (c < 1500) ? (($urandom % 2) != 0) : (($urandom % 8) != 0);
      tick();
    end
    aw_push = 1'b0; aw_slave_sel = '0;
    drain("rand_drain");
    neg();
    chk("stall_violation_flags", 32'(stall_violations), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
